// File: rtl/riscv_hwloop_unit.sv
// riscv_hwloop_unit
// Hardware-loop unit that sits beside the ID stage of the RI5CY core.
// Each loop i has three registers: start[i], end[i] and cnt[i].
// The unit compares the ID-stage PC against every live loop's end address.
// When a live loop matches, it redirects fetch to that loop's start address.
// The innermost loop, index 0, wins when several loops match.
// The selected loop's counter decrements when the end-of-body instruction
// leaves ID.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   current_pc_i                  PC of the instruction currently in ID
//   id_valid_i                    ID instruction advances to EX this cycle
//   we_start_i/we_end_i/we_cnt_i  field write strobes (all share wdata_i)
//   wr_lid_i, wdata_i             write target loop and data (low bits used)
//   rd_lid_i                      readback loop index
//   rd_start_o/rd_end_o/rd_cnt_o  combinational readback of stored fields
//   hwlp_active_o                 per-loop "counter non-zero" flags
//   hwlp_jump_o                   redirect fetch this cycle
//   hwlp_targ_addr_o              redirect target (zero when no jump)
//   hwlp_lid_o                    index of the selected loop (zero if none)
module riscv_hwloop_unit #(
    parameter int N_LOOPS = 2,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 32,
    parameter int LID_W   = (N_LOOPS > 1) ? $clog2(N_LOOPS) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [ADDR_W-1:0]                         current_pc_i,
    input  logic                                      id_valid_i,
    input  logic                                      we_start_i,
    input  logic                                      we_end_i,
    input  logic                                      we_cnt_i,
    input  logic [LID_W-1:0]                          wr_lid_i,
    input  logic [((ADDR_W > CNT_W) ? ADDR_W : CNT_W)-1:0] wdata_i,
    input  logic [LID_W-1:0]                          rd_lid_i,
    output logic [ADDR_W-1:0]                         rd_start_o,
    output logic [ADDR_W-1:0]                         rd_end_o,
    output logic [CNT_W-1:0]                          rd_cnt_o,
    output logic [N_LOOPS-1:0]                        hwlp_active_o,
    output logic                                      hwlp_jump_o,
    output logic [ADDR_W-1:0]                         hwlp_targ_addr_o,
    output logic [LID_W-1:0]                          hwlp_lid_o
);

    logic [ADDR_W-1:0]  start_r [N_LOOPS];
    logic [ADDR_W-1:0]  end_r   [N_LOOPS];
    logic [CNT_W-1:0]   cnt_r   [N_LOOPS];

    logic               sel_found_s;
    logic [LID_W-1:0]   sel_idx_s;
    logic [ADDR_W-1:0]  sel_start_s;
    logic [CNT_W-1:0]   sel_cnt_s;
    logic               jump_s;
    logic [N_LOOPS-1:0] wr_hit_s;
    logic [N_LOOPS-1:0] dec_s;

    // Priority match: scan from the outermost loop down so that the lowest index overwrites.
    always_comb begin
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        sel_start_s = '0;
        sel_cnt_s   = '0;
        for (int i = N_LOOPS - 1; i >= 0; i--) begin
            if ((cnt_r[i] != '0) && (current_pc_i == end_r[i])) begin
                sel_found_s = 1'b1;
                sel_idx_s   = LID_W'(i);
                sel_start_s = start_r[i];
                sel_cnt_s   = cnt_r[i];
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Redirect outputs: the last iteration (cnt == 1) falls through and does not jump.
    always_comb begin
        jump_s           = sel_found_s && (sel_cnt_s > CNT_W'(1));
        hwlp_jump_o      = jump_s;
        hwlp_lid_o       = sel_idx_s;
        if (jump_s) begin
            hwlp_targ_addr_o = sel_start_s;
        end else begin
            hwlp_targ_addr_o = '0;
        end
    end

    // Per-loop write hits, decrement enables and liveness flags.
    // Out-of-range write indices hit no loop, so those writes vanish.
    always_comb begin
        wr_hit_s      = '0;
        dec_s         = '0;
        hwlp_active_o = '0;
        for (int i = 0; i < N_LOOPS; i++) begin
            wr_hit_s[i]      = (wr_lid_i == LID_W'(i));
            dec_s[i]         = sel_found_s && id_valid_i && (sel_idx_s == LID_W'(i));
            hwlp_active_o[i] = (cnt_r[i] != '0);
        end
    end

    // Readback mux: stored values only; an out-of-range index reads zero.
    always_comb begin
        rd_start_o = '0;
        rd_end_o   = '0;
        rd_cnt_o   = '0;
        for (int i = 0; i < N_LOOPS; i++) begin
            if (rd_lid_i == LID_W'(i)) begin
                rd_start_o = start_r[i];
                rd_end_o   = end_r[i];
                rd_cnt_o   = cnt_r[i];
            end else begin
                rd_start_o = rd_start_o;
            end
        end
    end

    // Loop register file: CSR writes take precedence over the decrement of the same counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LOOPS; i++) begin
                start_r[i] <= '0;
                end_r[i]   <= '0;
                cnt_r[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_LOOPS; i++) begin
                if (we_start_i && wr_hit_s[i]) begin
                    start_r[i] <= wdata_i[ADDR_W-1:0];
                end else begin
                    start_r[i] <= start_r[i];
                end
                if (we_end_i && wr_hit_s[i]) begin
                    end_r[i] <= wdata_i[ADDR_W-1:0];
                end else begin
                    end_r[i] <= end_r[i];
                end
                if (we_cnt_i && wr_hit_s[i]) begin
                    cnt_r[i] <= wdata_i[CNT_W-1:0];
                end else if (dec_s[i]) begin
                    cnt_r[i] <= cnt_r[i] - CNT_W'(1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

endmodule

// File: doc/riscv_hwloop_unit.md
# riscv_hwloop_unit

Parametrised hardware-loop unit for the RI5CY core. It merges loop register storage with end-address detection and supports `N_LOOPS` independent, nestable loops. It sits beside the ID stage. It compares the current ID-stage PC against every stored end address and redirects fetch to the start address of the highest-priority live loop. It decrements that loop's counter when the end-of-body instruction leaves ID, and the CSR path programs it through a single write port.

## Interface
- `N_LOOPS`, default 2: number of loop register sets; index 0 is the innermost loop and has highest priority.
- `ADDR_W`, default 32: width of start and end addresses and of the PC.
- `CNT_W`, default 32: width of the iteration counter.
- `LID_W`, default `$clog2(N_LOOPS)` (minimum 1): width of the loop-index fields.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `current_pc_i`  in  ADDR_W  PC of the instruction currently in ID.
- `id_valid_i`  in  1  the instruction in ID advances to EX this cycle (not stalled, not killed).
- `we_start_i` / `we_end_i` / `we_cnt_i`  in  1 each  write strobes for the start, end and count fields.
- `wr_lid_i`  in  LID_W  loop index targeted by a write.
- `wdata_i`  in  max(ADDR_W,CNT_W)  write data; fields take the low bits.
- `rd_lid_i`  in  LID_W  loop index for the read port.
- `rd_start_o` / `rd_end_o`  out  ADDR_W  combinational readback of the stored start and end addresses.
- `rd_cnt_o`  out  CNT_W  combinational readback of the stored counter.
- `hwlp_active_o`  out  N_LOOPS  bit i is set when cnt[i] != 0.
- `hwlp_jump_o`  out  1  redirect fetch this cycle.
- `hwlp_targ_addr_o`  out  ADDR_W  redirect target; all zeros when `hwlp_jump_o`=0.
- `hwlp_lid_o`  out  LID_W  index of the selected loop; 0 when there is no match.

## Operation
- State per loop i: start[i], end[i], cnt[i]. All are 0 after reset.
- A loop is live when cnt[i] != 0.
- Match condition for loop i: `current_pc_i` == end[i] and the loop is live.
- Selection: the lowest-index matching loop wins. Higher-index matches in the same cycle are ignored and their counters are not touched.
- When the selected loop has cnt > 1:
  - `hwlp_jump_o`=1.
  - `hwlp_targ_addr_o`=start[sel].
- When the selected loop has cnt == 1: last iteration. `hwlp_jump_o`=0 (fall through), but the decrement still occurs.
- Decrement: at the clock edge where a loop is selected and `id_valid_i`=1, cnt[sel] becomes cnt[sel]-1.
  - There is no decrement while `id_valid_i`=0. The jump output still follows the match, so a stalled instruction keeps presenting the same redirect.
- cnt is unsigned. It never wraps, because a loop with cnt=0 can never match.
- Writes:
  - Each asserted strobe updates its field of loop `wr_lid_i` at the next edge.
  - Multiple strobes in one cycle are allowed and all use `wdata_i`.
  - If `wr_lid_i` >= `N_LOOPS`, the write is ignored.
- Write/decrement collision: if `we_cnt_i` targets the loop that is decrementing in the same cycle, the written value wins and the decrement is dropped. A start or end write to that loop does not block the decrement.
- Readback is combinational from the stored registers, so it does not yet reflect the same-cycle write. If `rd_lid_i` >= `N_LOOPS`, readback returns 0.
- Reset mid-loop: all counters clear immediately and all outputs go to 0 asynchronously.

## Timing
- `hwlp_jump_o`, `hwlp_targ_addr_o` and `hwlp_lid_o` are combinational from `current_pc_i` and the registered state, with zero-cycle latency.
- Counter and field updates take effect one clock after the strobe or decrement condition.
- A loop programmed in cycle T can match from cycle T+1.
- Reset value of every output:
  - `hwlp_jump_o`=0.
  - `hwlp_targ_addr_o`=0.
  - `hwlp_lid_o`=0.
  - `hwlp_active_o`=0.
  - The rd_* outputs read 0.

## Test plan
- Single loop, count 3:
  - Stimulus: loop 0 set to start=0x100, end=0x10C, cnt=3. Present PC 0x10C with `id_valid_i`=1 three times.
  - Response: jump to 0x100 twice, with cnt going 3→2→1. The third pass gives no jump and cnt→0, and `hwlp_active_o[0]` falls.
- Stall:
  - Stimulus: PC=end with cnt=2 and `id_valid_i`=0 for 4 cycles.
  - Response: `hwlp_jump_o`=1 every cycle and cnt stays at 2. On the first `id_valid_i`=1 cycle, cnt→1.
- Nested loops with a shared end:
  - Stimulus: loop 0 and loop 1 both have end=0x200, with cnt0=2 and cnt1=5.
  - Response: `hwlp_lid_o`=0, target=start[0], and only cnt0 decrements. Once cnt0=0, loop 1 is selected.
- Collision:
  - Stimulus: a decrement of loop 0 (cnt=4) in the same cycle as `we_cnt_i` to loop 0 with data 9.
  - Response: cnt0=9 next cycle.
- Zero and out-of-range:
  - Stimulus: cnt=0 with PC=end, then a write with `wr_lid_i`=`N_LOOPS`.
  - Response: no jump, target=0, and no state change.
- Asynchronous reset:
  - Stimulus: assert `rst_n`=0 between clock edges with cnt0=7.
  - Response: all outputs are 0 immediately and cnt0 reads 0 after release.
